// File: rtl/sram_arbiter_if.sv
// Bus bundle between the SRAM arbiter and its clients: the CPU port, the video
// refill port and the SRAM pad side. The arbiter sits on the slave modport;
// the surrounding system (CPU, video engine, pad buffers) uses the master one.
interface sram_arbiter_if;
    // CPU port
    logic        cpu_req;
    logic        cpu_wr;
    logic        cpu_ben;
    logic [19:0] cpu_adr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    // Video refill port
    logic        vid_req;
    logic [17:0] vid_adr;
    logic [31:0] vid_rdata;
    logic        vid_ack;
    // SRAM pad side
    logic [17:0] sr_adr;
    logic        sr_ce_n;
    logic        sr_oe_n;
    logic        sr_we_n;
    logic [3:0]  sr_be_n;
    logic [31:0] sr_dout;
    logic        sr_doe;
    logic [31:0] sr_din;

    modport master (
        output cpu_req, cpu_wr, cpu_ben, cpu_adr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output vid_req, vid_adr,
        input  vid_rdata, vid_ack,
        input  sr_adr, sr_ce_n, sr_oe_n, sr_we_n, sr_be_n, sr_dout, sr_doe,
        output sr_din
    );

    modport slave (
        input  cpu_req, cpu_wr, cpu_ben, cpu_adr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  vid_req, vid_adr,
        output vid_rdata, vid_ack,
        output sr_adr, sr_ce_n, sr_oe_n, sr_we_n, sr_be_n, sr_dout, sr_doe,
        input  sr_din
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter for a single asynchronous 32-bit SRAM. A CPU port (byte or
// word, read or write) and a video refill port (word reads) share the chip.
// Every SRAM-side output comes straight from a flop so sr_we_n cannot glitch.
// Write strobe width is WR_CYC cycles, framed by one setup and one hold cycle.
module sram_arbiter #(
    parameter int WR_CYC    = 2,     // cycles sr_we_n is held low (1..7)
    parameter bit VID_FIRST = 1'b1   // 1: video wins IDLE ties, 0: CPU wins
) (
    input logic          clk,
    input logic          rst,        // asynchronous, active-low
    sram_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,   // sample requests, SRAM idle
        VRD,    // video word read
        CRD,    // CPU read
        CWS,    // CPU write setup (address/data valid, we_n high)
        CWP,    // CPU write pulse (we_n low for WR_CYC cycles)
        CWH,    // CPU write hold (we_n high, address/data held)
        DONE    // CPU released, SRAM idle
    } state_t;

    state_t     state;
    logic [2:0] wr_cnt;      // cycles already spent in CWP
    logic       cpu_owed;    // last grant was video while the CPU was waiting
    logic       rd_byte;     // current CPU read is a byte access
    logic [1:0] rd_lane;     // byte lane selected by the current CPU read
    logic       grant_vid;   // video wins the IDLE decision this cycle
    logic [7:0] rd_lane_byte;

    // Arbitration: video takes the bus unless the CPU is also asking and
    // either the CPU is favoured or it was already passed over once.
    always_comb begin
        grant_vid = bus.vid_req & ~(bus.cpu_req & (cpu_owed | ~VID_FIRST));
    end

    // Byte lane of the SRAM read data addressed by the CPU (lane 0 = bits 7:0).
    always_comb begin
        rd_lane_byte = bus.sr_din[7:0];
        case (rd_lane)
            2'd0:    rd_lane_byte = bus.sr_din[7:0];
            2'd1:    rd_lane_byte = bus.sr_din[15:8];
            2'd2:    rd_lane_byte = bus.sr_din[23:16];
            default: rd_lane_byte = bus.sr_din[31:24];
        endcase
    end

    // The CPU may drop its request only in DONE, so stall everywhere else.
    assign bus.cpu_stall = bus.cpu_req & (state != DONE);

    // Access sequencer: next state and the registered SRAM/client outputs.
    // NOTE: outputs are assigned with <= alongside the state, so each SRAM
    // control value is the flop output for the state being entered -- the
    // pad signals therefore switch cleanly on the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the asynchronous reset lands on the SRAM control flops
            // directly, so an interrupted write has we_n released at once.
            state         <= IDLE;
            wr_cnt        <= 3'd0;
            cpu_owed      <= 1'b0;
            rd_byte       <= 1'b0;
            rd_lane       <= 2'd0;
            bus.sr_adr    <= 18'd0;
            bus.sr_ce_n   <= 1'b1;
            bus.sr_oe_n   <= 1'b1;
            bus.sr_we_n   <= 1'b1;
            bus.sr_be_n   <= 4'b1111;
            bus.sr_dout   <= 32'd0;
            bus.sr_doe    <= 1'b0;
            bus.cpu_rdata <= 32'd0;
            bus.vid_rdata <= 32'd0;
            bus.vid_ack   <= 1'b0;
        end else begin
            bus.vid_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vid) begin
                        state       <= VRD;
                        cpu_owed    <= bus.cpu_req;
                        bus.sr_adr  <= bus.vid_adr;
                        bus.sr_ce_n <= 1'b0;
                        bus.sr_oe_n <= 1'b0;
                        bus.sr_be_n <= 4'b0000;
                    end else if (bus.cpu_req) begin
                        cpu_owed    <= 1'b0;
                        rd_byte     <= bus.cpu_ben;
                        rd_lane     <= bus.cpu_adr[1:0];
                        bus.sr_adr  <= bus.cpu_adr[19:2];
                        bus.sr_ce_n <= 1'b0;
                        if (bus.cpu_wr) begin
                            state      <= CWS;
                            bus.sr_doe <= 1'b1;
                            if (bus.cpu_ben) begin
                                bus.sr_dout <= {4{bus.cpu_wdata[7:0]}};
                                bus.sr_be_n <= ~(4'b0001 << bus.cpu_adr[1:0]);
                            end else begin
                                bus.sr_dout <= bus.cpu_wdata;
                                bus.sr_be_n <= 4'b0000;
                            end
                        end else begin
                            state       <= CRD;
                            bus.sr_oe_n <= 1'b0;
                            bus.sr_be_n <= 4'b0000;
                        end
                    end
                end
                VRD: begin
                    state         <= IDLE;
                    bus.vid_rdata <= bus.sr_din;
                    bus.vid_ack   <= 1'b1;
                    bus.sr_ce_n   <= 1'b1;
                    bus.sr_oe_n   <= 1'b1;
                    bus.sr_be_n   <= 4'b1111;
                end
                CRD: begin
                    state         <= DONE;
                    bus.cpu_rdata <= rd_byte ? {24'd0, rd_lane_byte} : bus.sr_din;
                    bus.sr_ce_n   <= 1'b1;
                    bus.sr_oe_n   <= 1'b1;
                    bus.sr_be_n   <= 4'b1111;
                end
                CWS: begin
                    state       <= CWP;
                    wr_cnt      <= 3'd0;
                    bus.sr_we_n <= 1'b0;
                end
                CWP: begin
                    if (wr_cnt == 3'(WR_CYC - 1)) begin
                        state       <= CWH;
                        bus.sr_we_n <= 1'b1;
                    end else begin
                        wr_cnt <= wr_cnt + 3'd1;
                    end
                end
                CWH: begin
                    state       <= DONE;
                    bus.sr_ce_n <= 1'b1;
                    bus.sr_doe  <= 1'b0;
                    bus.sr_be_n <= 4'b1111;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    bus.sr_ce_n <= 1'b1;
                    bus.sr_oe_n <= 1'b1;
                    bus.sr_we_n <= 1'b1;
                    bus.sr_be_n <= 4'b1111;
                    bus.sr_doe  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a 16-word SRAM model behind the pads, a table of
// CPU transactions, and hand-written sequences for arbitration, a video
// request arriving mid-write and reset during a write pulse. Expected results
// are queued when stimulus is driven and compared when the DUT completes.
module tb_sram_arbiter;

    localparam int WR_CYC = 2;
    localparam logic [7:0] G_V = 8'h56;  // 'V'
    localparam logic [7:0] G_C = 8'h43;  // 'C'

    typedef struct {
        logic        wr;
        logic        ben;
        logic [19:0] adr;
        logic [31:0] wdata;
        logic [17:0] e_adr;
        logic [3:0]  e_be;
        logic [31:0] e_dout;
        logic [31:0] e_rdata;
        int          e_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    sram_arbiter_if bus ();

    sram_arbiter #(.WR_CYC(WR_CYC), .VID_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    // SRAM model: reads return the addressed word while oe_n is low.
    logic [31:0] mem [16];
    assign bus.sr_din = bus.sr_oe_n ? 32'h0 : mem[bus.sr_adr[3:0]];

    int n_checks = 0;
    int n_pass   = 0;

    vec_t        exp_q [$];
    logic [31:0] vid_q [$];
    logic [7:0]  grant_q [$];
    vec_t        vecs [10];

    // monitor state
    int          cyc = 0;
    int          lat_cnt = 0;
    int          we_cnt = 0;
    int          done_cyc = 0;
    int          ack_cyc = 0;
    bit          setup_ok = 0;
    bit          hold_ok = 0;
    bit          prev_setup = 0;
    bit          prev_we_low = 0;
    bit          prev_ack = 0;
    logic [17:0] last_rd_adr = '0;
    logic [17:0] w_adr = '0;
    logic [3:0]  w_be = '0;
    logic [31:0] w_dout = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic monitor();
        vec_t e;
        logic [31:0] ev;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                lat_cnt = 0; we_cnt = 0; setup_ok = 0; hold_ok = 0;
                prev_setup = 0; prev_we_low = 0; prev_ack = 0;
                continue;
            end
            // SRAM write model
            if (!bus.sr_we_n && !bus.sr_ce_n)
                for (int l = 0; l < 4; l++)
                    if (!bus.sr_be_n[l]) mem[bus.sr_adr[3:0]][8*l +: 8] = bus.sr_dout[8*l +: 8];
            // read cycles
            if (!bus.sr_ce_n && !bus.sr_oe_n) begin
                last_rd_adr = bus.sr_adr;
                check("rd_cycle_bus", 32'({bus.sr_be_n, bus.sr_doe, bus.sr_we_n}), 32'b0000_0_1);
            end
            // write strobe framing
            if (!bus.sr_we_n) begin
                if (we_cnt == 0) setup_ok = prev_setup;
                w_adr = bus.sr_adr; w_be = bus.sr_be_n; w_dout = bus.sr_dout;
                we_cnt++;
            end else if (prev_we_low) begin
                hold_ok = !bus.sr_ce_n && bus.sr_doe && bus.sr_oe_n &&
                          bus.sr_adr == w_adr && bus.sr_dout == w_dout && bus.sr_be_n == w_be;
            end
            if (bus.cpu_req) lat_cnt++;
            // CPU completion
            if (bus.cpu_req && !bus.cpu_stall) begin
                done_cyc = cyc;
                grant_q.push_back(G_C);
                if (exp_q.size() == 0) begin
                    check("cpu_spurious_done", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("cpu_latency", 32'(lat_cnt), 32'(e.e_lat));
                    check("done_sram_idle",
                          32'({bus.sr_ce_n, bus.sr_oe_n, bus.sr_we_n, bus.sr_doe, bus.sr_be_n}), 32'hEF);
                    if (e.wr) begin
                        check("wr_adr", 32'(w_adr), 32'(e.e_adr));
                        check("wr_be_n", 32'(w_be), 32'(e.e_be));
                        check("wr_dout", w_dout, e.e_dout);
                        check("wr_pulse_len", 32'(we_cnt), 32'(WR_CYC));
                        check("wr_setup", 32'(setup_ok), 32'd1);
                        check("wr_hold", 32'(hold_ok), 32'd1);
                    end else begin
                        check("rd_adr", 32'(last_rd_adr), 32'(e.e_adr));
                        check("cpu_rdata", bus.cpu_rdata, e.e_rdata);
                    end
                end
                lat_cnt = 0; we_cnt = 0; setup_ok = 0; hold_ok = 0;
            end
            // video completion
            if (bus.vid_ack) begin
                ack_cyc = cyc;
                grant_q.push_back(G_V);
                check("vid_ack_pulse", 32'(prev_ack), 32'd0);
                if (vid_q.size() == 0) begin
                    check("vid_spurious_ack", 32'(vid_q.size()), 32'd1);
                end else begin
                    ev = vid_q.pop_front();
                    check("vid_rdata", bus.vid_rdata, ev);
                end
            end
            prev_setup  = !bus.sr_ce_n && bus.sr_doe && bus.sr_we_n && bus.sr_oe_n;
            prev_we_low = !bus.sr_we_n;
            prev_ack    = bus.vid_ack;
        end
    endtask

    task automatic cpu_access(input vec_t v);
        bit got = 0;
        @(posedge clk); #1;
        bus.cpu_req   = 1'b1;
        bus.cpu_wr    = v.wr;
        bus.cpu_ben   = v.ben;
        bus.cpu_adr   = v.adr;
        bus.cpu_wdata = v.wdata;
        exp_q.push_back(v);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus.cpu_stall) begin got = 1; break; end
        end
        #1 bus.cpu_req = 1'b0;
        if (!got) check("cpu_timeout_stall", 32'(bus.cpu_stall), 32'd0);
    endtask

    task automatic vid_access(input logic [17:0] adr, input logic [31:0] exp);
        bit got = 0;
        #1;
        bus.vid_adr = adr;
        bus.vid_req = 1'b1;
        vid_q.push_back(exp);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.vid_ack) begin got = 1; break; end
        end
        #1 bus.vid_req = 1'b0;
        if (!got) check("vid_timeout_ack", 32'(bus.vid_ack), 32'd1);
    endtask

    initial begin
        logic [31:0] seq;
        vec_t        rv;
        int          dones;
        bit          seen;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h11223344;
        mem[1] = 32'h01020304;
        mem[2] = 32'hA0B0C0D0;
        mem[3] = 32'h55AA55AA;
        mem[4] = 32'hDEADBEEF;

        //         wr    ben   adr        wdata         e_adr      e_be     e_dout        e_rdata       lat
        vecs[0] = '{1'b0, 1'b0, 20'h00010, 32'h0,        18'h00004, 4'b0000, 32'h0,        32'hDEADBEEF, 3};
        vecs[1] = '{1'b0, 1'b1, 20'h00002, 32'h0,        18'h00000, 4'b0000, 32'h0,        32'h00000022, 3};
        vecs[2] = '{1'b1, 1'b1, 20'h00007, 32'h000000A5, 18'h00001, 4'b0111, 32'hA5A5A5A5, 32'h0,        WR_CYC + 4};
        vecs[3] = '{1'b0, 1'b0, 20'h00004, 32'h0,        18'h00001, 4'b0000, 32'h0,        32'hA5020304, 3};
        vecs[4] = '{1'b1, 1'b0, 20'h00014, 32'h12345678, 18'h00005, 4'b0000, 32'h12345678, 32'h0,        WR_CYC + 4};
        vecs[5] = '{1'b0, 1'b0, 20'h00014, 32'h0,        18'h00005, 4'b0000, 32'h0,        32'h12345678, 3};
        vecs[6] = '{1'b0, 1'b1, 20'h00015, 32'h0,        18'h00005, 4'b0000, 32'h0,        32'h00000056, 3};
        vecs[7] = '{1'b1, 1'b1, 20'h00000, 32'hFFFFFF3C, 18'h00000, 4'b1110, 32'h3C3C3C3C, 32'h0,        WR_CYC + 4};
        vecs[8] = '{1'b0, 1'b1, 20'h00003, 32'h0,        18'h00000, 4'b0000, 32'h0,        32'h00000011, 3};
        vecs[9] = '{1'b0, 1'b0, 20'h00000, 32'h0,        18'h00000, 4'b0000, 32'h0,        32'h1122333C, 3};

        bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_ben = 0; bus.cpu_adr = '0; bus.cpu_wdata = '0;
        bus.vid_req = 0; bus.vid_adr = '0;
        rst = 1'b0;
        fork monitor(); join_none

        // reset values
        #12;
        check("rst_ctrl", 32'({bus.sr_ce_n, bus.sr_oe_n, bus.sr_we_n, bus.sr_doe, bus.sr_be_n, bus.vid_ack}),
              32'b1110_1111_0);
        check("rst_sr_adr", 32'(bus.sr_adr), 32'd0);
        check("rst_sr_dout", bus.sr_dout, 32'd0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rst_vid_rdata", bus.vid_rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("idle_stall", 32'(bus.cpu_stall), 32'd0);
        check("idle_ce_n", 32'(bus.sr_ce_n), 32'd1);

        // table-driven CPU transactions
        for (int i = 0; i < 10; i++) cpu_access(vecs[i]);

        // lone video read
        @(posedge clk);
        vid_access(18'h00003, 32'h55AA55AA);

        // both request together and stay asserted: V, C, V, C
        grant_q.delete();
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_ben = 0; bus.cpu_adr = 20'h00010;
        bus.vid_req = 1; bus.vid_adr = 18'h00003;
        rv = '{1'b0, 1'b0, 20'h00010, 32'h0, 18'h00004, 4'b0000, 32'h0, 32'hDEADBEEF, 5};
        exp_q.push_back(rv); exp_q.push_back(rv);
        vid_q.push_back(32'h55AA55AA); vid_q.push_back(32'h55AA55AA);
        dones = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.cpu_req && !bus.cpu_stall) dones++;
            if (dones == 2) break;
        end
        #1; bus.cpu_req = 0; bus.vid_req = 0;
        check("both_dones", 32'(dones), 32'd2);
        seq = '0;
        foreach (grant_q[i]) if (i < 4) seq = {seq[23:0], grant_q[i]};
        check("grant_count", 32'(grant_q.size()), 32'd4);
        check("grant_seq", seq, {G_V, G_C, G_V, G_C});

        // video request arriving during the write pulse waits for IDLE
        rv = '{1'b1, 1'b0, 20'h00018, 32'h0F0F0F0F, 18'h00006, 4'b0000, 32'h0F0F0F0F, 32'h0, WR_CYC + 4};
        fork
            cpu_access(rv);
            begin
                seen = 0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (!bus.sr_we_n) begin seen = 1; break; end
                end
                check("midwr_we_seen", 32'(seen), 32'd1);
                vid_access(18'h00002, 32'hA0B0C0D0);
            end
        join
        check("vid_after_write_gap", 32'(ack_cyc - done_cyc), 32'd3);

        // reset during the write pulse
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_wr = 1; bus.cpu_ben = 0; bus.cpu_adr = 20'h0001C; bus.cpu_wdata = 32'h77777777;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!bus.sr_we_n) begin seen = 1; break; end
        end
        check("abort_we_seen", 32'(seen), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_we_doe", 32'({bus.sr_we_n, bus.sr_doe, bus.sr_ce_n}), 32'b101);
        check("abort_cpu_rdata", bus.cpu_rdata, 32'd0);
        bus.cpu_req = 0;
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("abort_released_stall", 32'(bus.cpu_stall), 32'd0);

        // fresh read after reset, uncontended latency
        cpu_access(vecs[0]);

        @(posedge clk); @(negedge clk);
        check("cpu_queue_empty", 32'(exp_q.size()), 32'd0);
        check("vid_queue_empty", 32'(vid_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WR_CYC, default 2, number of clk cycles sr_we_n is held low per write (legal 1..7).
REQ-002 SHALL have parameter VID_FIRST, default 1; 1 = video wins IDLE ties, 0 = CPU wins IDLE ties.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpu_req  in  1  CPU access request, held until the cycle cpu_stall=0.
REQ-006 SHALL have port cpu_wr  in  1  1 = write, 0 = read.
REQ-007 SHALL have port cpu_ben  in  1  1 = byte access, 0 = word access.
REQ-008 SHALL have port cpu_adr  in  20  CPU byte address.
REQ-009 SHALL have port cpu_wdata  in  32  CPU write data.
REQ-010 SHALL have port cpu_rdata  out  32  registered CPU read data.
REQ-011 SHALL have port cpu_stall  out  1  1 = CPU must hold its request.
REQ-012 SHALL have port vid_req  in  1  video refill request.
REQ-013 SHALL have port vid_adr  in  18  video word address.
REQ-014 SHALL have port vid_rdata  out  32  registered video data.
REQ-015 SHALL have port vid_ack  out  1  one-cycle pulse, vid_rdata valid.
REQ-016 SHALL have port sr_adr  out  18  SRAM word address.
REQ-017 SHALL have port sr_ce_n  out  1  SRAM chip enable, active-low.
REQ-018 SHALL have port sr_oe_n  out  1  SRAM output enable, active-low.
REQ-019 SHALL have port sr_we_n  out  1  SRAM write enable, active-low.
REQ-020 SHALL have port sr_be_n  out  4  byte-lane enables, active-low.
REQ-021 SHALL have port sr_dout  out  32  data to the SRAM pad buffers.
REQ-022 SHALL have port sr_doe  out  1  1 = pad buffers drive sr_dout.
REQ-023 SHALL have port sr_din  in  32  data from the SRAM pad buffers.

Function
REQ-024 SHALL implement states IDLE, VRD, CRD, CWS, CWP, CWH, DONE; requests are sampled only in IDLE.
REQ-025 SHALL, in IDLE: vid_req only -> VRD; cpu_req only -> CRD (cpu_wr=0) or CWS (cpu_wr=1); both -> winner per REQ-026; neither -> stay in IDLE.
REQ-026 SHALL, when both request in IDLE, grant the VID_FIRST-favoured port, except that the CPU wins if the last grant was video and cpu_req was pending at that grant (at most one video access between CPU accesses).
REQ-027 SHALL never preempt an access in progress; vid_req arriving mid-CPU-access waits for IDLE.
REQ-028 SHALL, in VRD (1 cycle): sr_adr=vid_adr, ce_n=0, oe_n=0, be_n=0000, doe=0; capture sr_din into vid_rdata at the cycle end; pulse vid_ack the next cycle (IDLE).
REQ-029 SHALL, in CRD (1 cycle): sr_adr=cpu_adr[19:2], ce_n=0, oe_n=0; capture at the cycle end -> DONE.
REQ-030 SHALL, on a byte read, set cpu_rdata = {24'b0, lane cpu_adr[1:0] of sr_din}; on a word read, cpu_rdata = sr_din.
REQ-031 SHALL, in CWS (1 cycle): address, ce_n=0, doe=1, we_n=1, oe_n=1; then CWP for exactly WR_CYC cycles with we_n=0; then CWH (1 cycle) with we_n=1 and address/data/doe held; then DONE.
REQ-032 SHALL, on a byte write, drive sr_dout = cpu_wdata[7:0] replicated to all lanes, with only lane cpu_adr[1:0] active in be_n (lane 0 = bits 7:0); on a word write, sr_dout = cpu_wdata and be_n=0000.
REQ-033 SHALL, in DONE (1 cycle): cpu_stall=0, cpu_rdata valid, SRAM idle; then IDLE.
REQ-034 SHALL assert cpu_stall=1 whenever cpu_req=1 and state is not DONE; cpu_stall=0 when cpu_req=0.
REQ-035 SHALL drive SRAM signals to the idle values ce_n=oe_n=we_n=1, doe=0, be_n=1111 in IDLE and DONE.
REQ-036 SHALL register all SRAM-side outputs (no combinational glitches on sr_we_n).
REQ-037 SHALL make CPU read latency 3 cycles (IDLE, CRD, DONE) and write latency WR_CYC+4 cycles, uncontended.

Reset
REQ-038 SHALL, on rst=0, asynchronously force state=IDLE, ce_n=oe_n=we_n=1, doe=0, be_n=1111, sr_adr=0, sr_dout=0, cpu_rdata=0, vid_rdata=0, vid_ack=0, and clear the last-grant flag.
REQ-039 SHALL abort an in-progress write immediately on reset (we_n high within the same cycle); the partial write is not retried.

Verification
REQ-040 SHALL pass: word read, cpu_adr=0x00010, sr_din=0xDEADBEEF -> sr_adr=0x00004, cpu_stall low on cycle 3, cpu_rdata=0xDEADBEEF.
REQ-041 SHALL pass: byte write, cpu_adr=0x00007, wdata=0x000000A5, WR_CYC=2 -> sr_be_n=0111, sr_dout=0xA5A5A5A5, we_n low for exactly 2 cycles, framed by 1 setup and 1 hold cycle.
REQ-042 SHALL pass: vid_req and cpu_req rise together with VID_FIRST=1 -> VRD first, vid_ack pulses once, then the CPU access; with both held continuously, grants alternate V,C,V,C.
REQ-043 SHALL pass: vid_req rises during CWP -> the write completes unchanged and VRD starts in the cycle after the next IDLE.
REQ-044 SHALL pass: rst=0 asserted during CWP -> sr_we_n=1 and sr_doe=0 before the next edge, state IDLE, cpu_rdata=0.
REQ-045 SHALL pass: byte read, cpu_adr=0x00002, sr_din=0x11223344 -> cpu_rdata=0x00000022.
